// File: rtl/histogram_top.sv
// rtl/histogram_top.sv - binary image scan with 3-tap vertical majority filter and x/y histograms
//
// Scans a 240x180 1-bit image held in an external synchronous-read memory,
// filters each pixel with a vertical majority of 3, stores the filtered image
// internally, and accumulates column/row histograms plus a saturating count
// of set filtered pixels. Results are read back while idle.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   start                 level; rising edge starts a scan, low returns to IDLE
//   threshold[12:0]       minimum activeWindows for wakeUp
//   binaryDataIn          pixel from external memory (1 cycle after address)
//   xAddressIn/yAddressIn readout address
//   readMedianImage       enable filtered-image readout
//   readHistogram         enable histogram readout
//   xAddressOut/yAddressOut scan address to external memory (0 outside SCAN)
//   binaryMemWriteEnable  external memory load enable (IDLE with start low)
//   fullImageDone, wakeUp scan complete / complete with enough activity
//   filteredDataOut       registered filtered pixel readout
//   xHistogramOut/yHistogramOut, xValid/yValid  registered histogram readout

module histogram_top (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] threshold,
  input  logic        binaryDataIn,
  input  logic [7:0]  xAddressIn,
  input  logic [7:0]  yAddressIn,
  input  logic        readMedianImage,
  input  logic        readHistogram,
  output logic [7:0]  xAddressOut,
  output logic [7:0]  yAddressOut,
  output logic        binaryMemWriteEnable,
  output logic        fullImageDone,
  output logic        wakeUp,
  output logic        filteredDataOut,
  output logic [7:0]  xHistogramOut,
  output logic [7:0]  yHistogramOut,
  output logic        xValid,
  output logic        yValid
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t      state, state_next;
  logic        start_d;
  logic        start_rise;
  logic        scan_entry;
  logic        scan_last;
  logic [7:0]  x_cnt, y_cnt;

  // pixel arriving from the external memory this cycle and its coordinates
  logic        b_valid;
  logic [7:0]  b_x, b_y;
  // s1 = p(x, b_y-1), s0 = p(x, b_y-2) relative to the arriving pixel
  logic        s0, s1;
  // the last filtered pixel of a column is emitted one cycle after its column ends
  logic        tail_pending;
  logic [7:0]  tail_x;

  logic        f_en, f_val, commit;
  logic [7:0]  f_x, f_y;

  logic [7:0]  xhist [0:239];
  logic [7:0]  yhist [0:179];
  logic        fmem  [0:239][0:179];
  logic [12:0] active_windows;

  assign start_rise = start & ~start_d;
  assign scan_entry = (state == IDLE) && (state_next == SCAN);
  assign scan_last  = (x_cnt == 8'd239) && (y_cnt == 8'd179);
  assign commit     = f_en && ((state == SCAN) || (state == FLUSH));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      start_d <= start;  // a start held through reset is not a rising edge
    end else begin
      state   <= state_next;
      start_d <= start;
    end
  end

  always_comb begin
    state_next = state;
    if (!start) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_rise)   state_next = SCAN;
        SCAN:    if (scan_last)    state_next = FLUSH;
        FLUSH:   if (tail_pending) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // scan address counters: y inner, x outer
  always_ff @(posedge clk) begin
    if (!reset || scan_entry) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (state == SCAN && !scan_last) begin
      if (y_cnt == 8'd179) begin
        y_cnt <= '0;
        x_cnt <= x_cnt + 8'd1;
      end else begin
        y_cnt <= y_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      b_valid      <= 1'b0;
      b_x          <= '0;
      b_y          <= '0;
      s0           <= 1'b0;
      s1           <= 1'b0;
      tail_pending <= 1'b0;
      tail_x       <= '0;
    end else begin
      b_valid      <= (state == SCAN) && start;
      b_x          <= x_cnt;
      b_y          <= y_cnt;
      tail_pending <= b_valid && (b_y == 8'd179);
      tail_x       <= b_x;
      if (b_valid) begin
        s0 <= (b_y == 8'd0) ? 1'b0 : s1;
        s1 <= binaryDataIn;
      end
    end
  end

  // The arriving pixel completes the window of the pixel above it; the
  // bottom pixel of a column has a zero below and is emitted from the tail slot.
  always_comb begin
    f_en  = 1'b0;
    f_val = 1'b0;
    f_x   = '0;
    f_y   = '0;
    if (b_valid && (b_y != 8'd0)) begin
      f_en  = 1'b1;
      f_val = (s0 & s1) | (s0 & binaryDataIn) | (s1 & binaryDataIn);
      f_x   = b_x;
      f_y   = b_y - 8'd1;
    end else if (tail_pending) begin
      f_en  = 1'b1;
      f_val = s0 & s1;
      f_x   = tail_x;
      f_y   = 8'd179;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || scan_entry) begin
      for (int i = 0; i < 240; i++) xhist[i] <= '0;
      for (int i = 0; i < 180; i++) yhist[i] <= '0;
      active_windows <= '0;
    end else if (commit && f_val) begin
      xhist[f_x] <= xhist[f_x] + 8'd1;
      yhist[f_y] <= yhist[f_y] + 8'd1;
      if (active_windows != 13'h1FFF) active_windows <= active_windows + 13'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) fmem[f_x][f_y] <= f_val;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      filteredDataOut <= 1'b0;
      xHistogramOut   <= '0;
      yHistogramOut   <= '0;
      xValid          <= 1'b0;
      yValid          <= 1'b0;
    end else begin
      filteredDataOut <= 1'b0;
      xHistogramOut   <= '0;
      yHistogramOut   <= '0;
      xValid          <= 1'b0;
      yValid          <= 1'b0;
      if (state == IDLE) begin
        if (readMedianImage && xAddressIn < 8'd240 && yAddressIn < 8'd180)
          filteredDataOut <= fmem[xAddressIn][yAddressIn];
        if (readHistogram && xAddressIn < 8'd240) begin
          xHistogramOut <= xhist[xAddressIn];
          xValid        <= 1'b1;
        end
        if (readHistogram && yAddressIn < 8'd180) begin
          yHistogramOut <= yhist[yAddressIn];
          yValid        <= 1'b1;
        end
      end
    end
  end

  assign xAddressOut          = (state == SCAN) ? x_cnt : 8'd0;
  assign yAddressOut          = (state == SCAN) ? y_cnt : 8'd0;
  assign binaryMemWriteEnable = (state == IDLE) && !start;
  assign fullImageDone        = (state == DONE);
  assign wakeUp               = (state == DONE) && (active_windows >= threshold);

endmodule

// File: tb/tb_histogram_top.sv
// tb/tb_histogram_top.sv - directed table-driven bench for histogram_top

module tb_histogram_top;

  logic        clk = 1'b0;
  logic        reset, start, binaryDataIn, readMedianImage, readHistogram;
  logic [12:0] threshold;
  logic [7:0]  xAddressIn, yAddressIn;
  logic [7:0]  xAddressOut, yAddressOut, xHistogramOut, yHistogramOut;
  logic        binaryMemWriteEnable, fullImageDone, wakeUp, filteredDataOut, xValid, yValid;

  always #5 clk = ~clk;

  histogram_top dut (
    .clk(clk), .reset(reset), .start(start), .threshold(threshold),
    .binaryDataIn(binaryDataIn), .xAddressIn(xAddressIn), .yAddressIn(yAddressIn),
    .readMedianImage(readMedianImage), .readHistogram(readHistogram),
    .xAddressOut(xAddressOut), .yAddressOut(yAddressOut),
    .binaryMemWriteEnable(binaryMemWriteEnable), .fullImageDone(fullImageDone),
    .wakeUp(wakeUp), .filteredDataOut(filteredDataOut),
    .xHistogramOut(xHistogramOut), .yHistogramOut(yHistogramOut),
    .xValid(xValid), .yValid(yValid)
  );

  // external image memory: synchronous read
  logic img [0:239][0:179];
  always @(posedge clk) begin
    if (xAddressOut < 8'd240 && yAddressOut < 8'd180) binaryDataIn <= img[xAddressOut][yAddressOut];
    else binaryDataIn <= 1'b0;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] xa;
    logic [7:0] ya;
    logic       rm;
    logic       rh;
    logic       ef;
    logic [7:0] exh;
    logic       exv;
    logic [7:0] eyh;
    logic       eyv;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int xa, input int ya, input int rm, input int rh,
                              input int ef, input int exh, input int exv, input int eyh, input int eyv);
    vec_t v;
    v.xa = 8'(xa); v.ya = 8'(ya); v.rm = 1'(rm); v.rh = 1'(rh);
    v.ef = 1'(ef); v.exh = 8'(exh); v.exv = 1'(exv); v.eyh = 8'(eyh); v.eyv = 1'(eyv);
    return v;
  endfunction

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      xAddressIn      = vq[i].xa;
      yAddressIn      = vq[i].ya;
      readMedianImage = vq[i].rm;
      readHistogram   = vq[i].rh;
      tick();
      chk($sformatf("%s[%0d] filtered", tag, i), filteredDataOut, vq[i].ef);
      chk($sformatf("%s[%0d] xhist", tag, i), xHistogramOut, vq[i].exh);
      chk($sformatf("%s[%0d] xvalid", tag, i), xValid, vq[i].exv);
      chk($sformatf("%s[%0d] yhist", tag, i), yHistogramOut, vq[i].eyh);
      chk($sformatf("%s[%0d] yvalid", tag, i), yValid, vq[i].eyv);
    end
    vq.delete();
    readMedianImage = 1'b0;
    readHistogram   = 1'b0;
  endtask

  task automatic run_scan(input logic [12:0] th, input string tag);
    int n;
    n = 0;
    threshold = th;
    start = 1'b1;
    while (!fullImageDone && n < 43400) begin
      tick();
      n++;
      if (n == 1) begin
        chk({tag, " addr0 x"}, xAddressOut, 0);
        chk({tag, " addr0 y"}, yAddressOut, 0);
      end
      if (n == 2) begin
        chk({tag, " addr1 y"}, yAddressOut, 1);
        chk({tag, " we in scan"}, binaryMemWriteEnable, 0);
      end
      if (n == 183) begin
        chk({tag, " addr182 x"}, xAddressOut, 1);
        chk({tag, " addr182 y"}, yAddressOut, 2);
      end
    end
    chk({tag, " done within budget"}, int'(fullImageDone && n <= 43208), 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; threshold = 13'd50;
    readMedianImage = 1'b0; readHistogram = 1'b0;
    xAddressIn = '0; yAddressIn = '0;
    for (int x = 0; x < 240; x++)
      for (int y = 0; y < 180; y++) img[x][y] = 1'b0;

    tick(); tick();
    chk("reset done", fullImageDone, 0);
    chk("reset wake", wakeUp, 0);
    chk("reset xaddr", xAddressOut, 0);
    chk("reset xvalid", xValid, 0);
    chk("reset yvalid", yValid, 0);
    reset = 1'b1;
    tick();
    chk("idle we", binaryMemWriteEnable, 1);
    readHistogram = 1'b1;
    tick();
    chk("reset hist xvalid", xValid, 1);
    chk("reset hist x0", xHistogramOut, 0);
    chk("reset hist y0", yHistogramOut, 0);
    readHistogram = 1'b0;

    // image A: column x=5, isolated pixel (10,10), short runs at x=3
    for (int y = 0; y < 180; y++) img[5][y] = 1'b1;
    img[10][10] = 1'b1;
    img[3][0] = 1'b1; img[3][1] = 1'b1; img[3][3] = 1'b1;
    img[3][178] = 1'b1; img[3][179] = 1'b1;

    // abort a scan with reset partway through
    start = 1'b1;
    repeat (100) tick();
    chk("abort pre y", yAddressOut, 99);
    reset = 1'b0;
    tick();
    chk("abort xaddr", xAddressOut, 0);
    chk("abort yaddr", yAddressOut, 0);
    chk("abort done", fullImageDone, 0);
    chk("abort wake", wakeUp, 0);
    chk("abort we", binaryMemWriteEnable, 0);
    chk("abort filt", filteredDataOut, 0);
    chk("abort xvalid", xValid, 0);
    reset = 1'b1;
    tick();
    chk("held start no rescan", yAddressOut, 0);
    start = 1'b0;
    tick();
    chk("idle we again", binaryMemWriteEnable, 1);

    run_scan(13'd50, "A");
    chk("A done", fullImageDone, 1);
    chk("A wake th50", wakeUp, 1);
    repeat (3) tick();
    chk("A done holds", fullImageDone, 1);
    threshold = 13'd185; #1;
    chk("A wake th185", wakeUp, 1);
    threshold = 13'd186; #1;
    chk("A wake th186", wakeUp, 0);
    threshold = 13'd200; #1;
    chk("A wake th200", wakeUp, 0);
    threshold = 13'd50;
    start = 1'b0;
    tick();
    chk("A stop done", fullImageDone, 0);
    chk("A stop wake", wakeUp, 0);
    chk("A stop we", binaryMemWriteEnable, 1);

    // readout latency: value must not appear before the next edge
    xAddressIn = 8'd5; yAddressIn = 8'd100; readHistogram = 1'b1;
    #1;
    chk("latency pre xvalid", xValid, 0);
    tick();
    chk("latency post xvalid", xValid, 1);
    chk("latency post xhist", xHistogramOut, 180);

    vq.push_back(mk(3, 0, 1, 1,     1, 5, 1,   2, 1));
    vq.push_back(mk(3, 3, 1, 1,     0, 5, 1,   1, 1));
    vq.push_back(mk(3, 2, 1, 1,     1, 5, 1,   2, 1));
    vq.push_back(mk(10, 10, 1, 1,   0, 0, 1,   1, 1));
    vq.push_back(mk(5, 179, 1, 1,   1, 180, 1, 2, 1));
    vq.push_back(mk(240, 180, 1, 1, 0, 0, 0,   0, 0));
    vq.push_back(mk(5, 100, 1, 0,   1, 0, 0,   0, 0));
    vq.push_back(mk(5, 100, 0, 1,   0, 180, 1, 1, 1));
    vq.push_back(mk(239, 178, 1, 1, 0, 0, 1,   2, 1));
    vq.push_back(mk(240, 3, 1, 1,   0, 0, 0,   1, 1));
    vq.push_back(mk(4, 180, 1, 1,   0, 0, 1,   0, 0));
    vq.push_back(mk(3, 177, 1, 1,   0, 5, 1,   1, 1));
    vq.push_back(mk(5, 0, 1, 1,     1, 180, 1, 2, 1));
    vq.push_back(mk(3, 179, 0, 0,   0, 0, 0,   0, 0));
    run_vecs("A");

    // image B: all ones, activeWindows saturates
    for (int x = 0; x < 240; x++)
      for (int y = 0; y < 180; y++) img[x][y] = 1'b1;
    run_scan(13'd8191, "B");
    chk("B wake saturated", wakeUp, 1);
    start = 1'b0;
    tick();
    vq.push_back(mk(0, 0, 1, 1,     1, 180, 1, 240, 1));
    vq.push_back(mk(239, 179, 1, 1, 1, 180, 1, 240, 1));
    vq.push_back(mk(240, 180, 1, 1, 0, 0, 0,   0, 0));
    vq.push_back(mk(120, 90, 1, 1,  1, 180, 1, 240, 1));
    run_vecs("B");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
